// File: rtl/heat_sequencer_if.sv
// Signal bundle between the cooking-state controller and the heat sequencer.
// All signals are levels sampled every clk_1Khz edge; there is no valid/ready handshake.
interface heat_sequencer_if;
    logic       power_on;
    logic [2:0] state;
    logic [3:0] mode;
    logic       heater;
    logic       fan;
    logic [1:0] phase;
    logic       busy;

    modport master (
        output power_on, state, mode,
        input  heater, fan, phase, busy
    );

    modport slave (
        input  power_on, state, mode,
        output heater, fan, phase, busy
    );
endinterface

// File: rtl/heat_sequencer.sv
// Heater/fan power sequencer: preheat, mode-dependent PWM heat, fan cool-down, off.
// The phase output is the FSM state register itself.
module heat_sequencer #(
    parameter int unsigned T_1S       = 1000,
    parameter int unsigned PWM_PERIOD = 100,
    parameter int unsigned DUTY_M1    = 30,
    parameter int unsigned DUTY_M2    = 60,
    parameter int unsigned DUTY_M3    = 90,
    parameter int unsigned PREHEAT_S  = 3,
    parameter int unsigned COOLDOWN_S = 5
) (
    input  logic             clk_1Khz,
    input  logic             rst,
    heat_sequencer_if.slave  hs
);

    typedef enum logic [1:0] {
        PH_OFF     = 2'd0,
        PH_PREHEAT = 2'd1,
        PH_HEAT    = 2'd2,
        PH_COOL    = 2'd3
    } phase_t;

    localparam logic [2:0]  ST_WORK   = 3'd1;
    localparam logic [15:0] MS_LAST   = 16'(T_1S - 1);
    localparam logic [15:0] PWM_LAST  = 16'(PWM_PERIOD - 1);
    localparam logic [15:0] PRE_LAST  = 16'(PREHEAT_S - 1);
    localparam logic [15:0] COOL_LAST = 16'(COOLDOWN_S - 1);

    phase_t      phase_q, phase_nxt;
    logic [15:0] ms_cnt, ms_nxt;
    logic [15:0] sec_cnt, sec_nxt;
    logic [15:0] pwm_cnt, pwm_nxt;
    logic [15:0] duty_lat, duty_nxt, duty_sel;
    logic        heater_q, heater_nxt;
    logic        fan_q, fan_nxt;
    logic        busy_q;
    logic        work, ms_wrap;

    assign work    = (hs.state == ST_WORK);
    assign ms_wrap = (ms_cnt == MS_LAST);

    // Mode 0 behaves as mode 1; anything above 3 behaves as mode 3.
    always_comb begin
        duty_sel = 16'(DUTY_M3);
        case (hs.mode)
            4'd0, 4'd1: duty_sel = 16'(DUTY_M1);
            4'd2:       duty_sel = 16'(DUTY_M2);
            default:    duty_sel = 16'(DUTY_M3);
        endcase
    end

    always_comb begin
        phase_nxt  = phase_q;
        ms_nxt     = ms_wrap ? 16'd0 : ms_cnt + 16'd1;
        sec_nxt    = ms_wrap ? sec_cnt + 16'd1 : sec_cnt;
        pwm_nxt    = (pwm_cnt == PWM_LAST) ? 16'd0 : pwm_cnt + 16'd1;
        duty_nxt   = duty_lat;
        heater_nxt = 1'b0;
        fan_nxt    = 1'b0;

        case (phase_q)
            PH_OFF:     if (work) phase_nxt = PH_PREHEAT;
            PH_PREHEAT: begin
                // A state change outranks the preheat timer on the same edge.
                if (!work)                              phase_nxt = PH_COOL;
                else if (ms_wrap && sec_cnt == PRE_LAST) phase_nxt = PH_HEAT;
            end
            PH_HEAT:    if (!work) phase_nxt = PH_COOL;
            PH_COOL: begin
                if (work)                                 phase_nxt = PH_HEAT;
                else if (ms_wrap && sec_cnt == COOL_LAST) phase_nxt = PH_OFF;
            end
            default:    phase_nxt = PH_OFF;
        endcase

        if (!hs.power_on) phase_nxt = PH_OFF;

        if (phase_nxt != phase_q || phase_q == PH_OFF) begin
            ms_nxt  = 16'd0;
            sec_nxt = 16'd0;
            pwm_nxt = 16'd0;
        end

        // Duty is only sampled at period boundaries so a mode change never cuts a pulse short.
        if (phase_nxt == PH_HEAT && (phase_q != PH_HEAT || pwm_cnt == PWM_LAST))
            duty_nxt = duty_sel;

        case (phase_nxt)
            PH_PREHEAT: begin heater_nxt = 1'b1;                 fan_nxt = 1'b1; end
            PH_HEAT:    begin heater_nxt = (pwm_nxt < duty_nxt); fan_nxt = 1'b1; end
            PH_COOL:    begin heater_nxt = 1'b0;                 fan_nxt = 1'b1; end
            default:    begin heater_nxt = 1'b0;                 fan_nxt = 1'b0; end
        endcase
    end

    always_ff @(posedge clk_1Khz or negedge rst) begin
        if (!rst) begin
            phase_q  <= PH_OFF;
            ms_cnt   <= 16'd0;
            sec_cnt  <= 16'd0;
            pwm_cnt  <= 16'd0;
            duty_lat <= 16'd0;
            heater_q <= 1'b0;
            fan_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            phase_q  <= phase_nxt;
            ms_cnt   <= ms_nxt;
            sec_cnt  <= sec_nxt;
            pwm_cnt  <= pwm_nxt;
            duty_lat <= duty_nxt;
            heater_q <= heater_nxt;
            fan_q    <= fan_nxt;
            busy_q   <= (phase_nxt != PH_OFF);
        end
    end

    assign hs.phase  = phase_q;
    assign hs.heater = heater_q;
    assign hs.fan    = fan_q;
    assign hs.busy   = busy_q;

endmodule

// File: tb/tb_heat_sequencer.sv
// Directed bench for heat_sequencer: phase timing, PWM duty, mode latching, cool-down, power-off and reset.
module tb_heat_sequencer;
    logic clk_1Khz = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [1:0] P_OFF = 2'd0, P_PRE = 2'd1, P_HEAT = 2'd2, P_COOL = 2'd3;
    localparam logic [2:0] S_IDLE = 3'd0, S_WORK = 3'd1, S_PAUSE = 3'd4;

    heat_sequencer_if hif();

    heat_sequencer dut (
        .clk_1Khz (clk_1Khz),
        .rst      (rst),
        .hs       (hif.slave)
    );

    always #5 clk_1Khz = ~clk_1Khz;

    // Outputs are sampled and inputs changed on the falling edge.
    task automatic tick();
        @(negedge clk_1Khz);
    endtask

    task automatic count_phase(input logic [1:0] ph, input int budget,
                               output int n, output int heater_lows, output int fan_lows);
        n = 0; heater_lows = 0; fan_lows = 0;
        while (hif.phase == ph && n < budget) begin
            n++;
            if (!hif.heater) heater_lows++;
            if (!hif.fan)    fan_lows++;
            tick();
        end
    endtask

    task automatic count_highs(input int cycles, output int highs, output int fan_lows);
        highs = 0; fan_lows = 0;
        for (int i = 0; i < cycles; i++) begin
            if (hif.heater) highs++;
            if (!hif.fan)   fan_lows++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; hif.power_on = 1'b0; hif.state = S_IDLE; hif.mode = 4'd0;
        repeat (3) tick();
        vectors++; if (hif.heater !== 1'b0) begin miscompares++; $display("FAIL reset_heater: got %b expected 0", hif.heater); end
        vectors++; if (hif.fan !== 1'b0)    begin miscompares++; $display("FAIL reset_fan: got %b expected 0", hif.fan); end
        vectors++; if (hif.phase !== P_OFF) begin miscompares++; $display("FAIL reset_phase: got %0d expected %0d", hif.phase, P_OFF); end
        vectors++; if (hif.busy !== 1'b0)   begin miscompares++; $display("FAIL reset_busy: got %b expected 0", hif.busy); end
        rst = 1'b1;
        tick();
        vectors++; if (hif.phase !== P_OFF) begin miscompares++; $display("FAIL idle_after_reset: got %0d expected %0d", hif.phase, P_OFF); end
    endtask

    task automatic test_preheat();
        int n, hl, fl;
        hif.power_on = 1'b1; hif.state = S_WORK; hif.mode = 4'd2;
        tick();
        vectors++; if (hif.phase !== P_PRE) begin miscompares++; $display("FAIL preheat_entry: got %0d expected %0d", hif.phase, P_PRE); end
        vectors++; if ({hif.heater, hif.fan, hif.busy} !== 3'b111) begin miscompares++; $display("FAIL preheat_outputs: got %b expected 111", {hif.heater, hif.fan, hif.busy}); end
        count_phase(P_PRE, 4000, n, hl, fl);
        vectors++; if (n !== 3000)          begin miscompares++; $display("FAIL preheat_length: got %0d expected 3000", n); end
        vectors++; if (hl !== 0 || fl !== 0) begin miscompares++; $display("FAIL preheat_drive: got %0d/%0d low cycles expected 0/0", hl, fl); end
        vectors++; if (hif.phase !== P_HEAT) begin miscompares++; $display("FAIL preheat_to_heat: got %0d expected %0d", hif.phase, P_HEAT); end
    endtask

    task automatic test_pwm_mode2();
        int h, fl;
        for (int p = 0; p < 3; p++) begin
            count_highs(100, h, fl);
            vectors++; if (h !== 60)  begin miscompares++; $display("FAIL pwm_m2_high p%0d: got %0d expected 60", p, h); end
            vectors++; if (fl !== 0)  begin miscompares++; $display("FAIL pwm_m2_fan p%0d: got %0d fan-low cycles expected 0", p, fl); end
        end
    endtask

    task automatic test_mode_change();
        int h, fl;
        hif.mode = 4'd1;
        count_highs(100, h, fl);
        vectors++; if (h !== 60) begin miscompares++; $display("FAIL mode_latched_old: got %0d expected 60", h); end
        h = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) hif.mode = 4'd3;
            if (hif.heater) h++;
            tick();
        end
        vectors++; if (h !== 30) begin miscompares++; $display("FAIL mode_change_current: got %0d expected 30", h); end
        count_highs(100, h, fl);
        vectors++; if (h !== 90) begin miscompares++; $display("FAIL mode_change_next: got %0d expected 90", h); end
    endtask

    task automatic test_cool();
        int n, hl, fl;
        hif.state = S_PAUSE;
        tick();
        vectors++; if (hif.phase !== P_COOL) begin miscompares++; $display("FAIL cool_entry: got %0d expected %0d", hif.phase, P_COOL); end
        vectors++; if ({hif.heater, hif.fan, hif.busy} !== 3'b011) begin miscompares++; $display("FAIL cool_outputs: got %b expected 011", {hif.heater, hif.fan, hif.busy}); end
        count_phase(P_COOL, 6000, n, hl, fl);
        vectors++; if (n !== 5000)           begin miscompares++; $display("FAIL cool_length: got %0d expected 5000", n); end
        vectors++; if (fl !== 0 || hl !== n) begin miscompares++; $display("FAIL cool_drive: got fan-low %0d heater-low %0d expected 0 and %0d", fl, hl, n); end
        vectors++; if (hif.phase !== P_OFF)  begin miscompares++; $display("FAIL cool_to_off: got %0d expected %0d", hif.phase, P_OFF); end
        vectors++; if ({hif.heater, hif.fan, hif.busy} !== 3'b000) begin miscompares++; $display("FAIL off_outputs: got %b expected 000", {hif.heater, hif.fan, hif.busy}); end
    endtask

    task automatic test_cool_resume();
        int n, hl, fl;
        hif.state = S_WORK;
        tick();
        count_phase(P_PRE, 4000, n, hl, fl);
        vectors++; if (hif.phase !== P_HEAT) begin miscompares++; $display("FAIL resume_setup: got %0d expected %0d", hif.phase, P_HEAT); end
        hif.state = S_PAUSE;
        repeat (2000) tick();
        vectors++; if (hif.phase !== P_COOL) begin miscompares++; $display("FAIL resume_in_cool: got %0d expected %0d", hif.phase, P_COOL); end
        hif.state = S_WORK;
        tick();
        vectors++; if (hif.phase !== P_HEAT) begin miscompares++; $display("FAIL resume_skip_preheat: got %0d expected %0d", hif.phase, P_HEAT); end
        vectors++; if ({hif.heater, hif.fan} !== 2'b11) begin miscompares++; $display("FAIL resume_outputs: got %b expected 11", {hif.heater, hif.fan}); end
    endtask

    task automatic test_power_off();
        hif.power_on = 1'b0;
        tick();
        vectors++; if (hif.phase !== P_OFF) begin miscompares++; $display("FAIL poweroff_phase: got %0d expected %0d", hif.phase, P_OFF); end
        vectors++; if ({hif.heater, hif.fan, hif.busy} !== 3'b000) begin miscompares++; $display("FAIL poweroff_outputs: got %b expected 000", {hif.heater, hif.fan, hif.busy}); end
        repeat (5) tick();
        vectors++; if (hif.phase !== P_OFF) begin miscompares++; $display("FAIL poweroff_hold: got %0d expected %0d", hif.phase, P_OFF); end
    endtask

    task automatic test_mode_clamp();
        int n, hl, fl, h;
        hif.mode = 4'd0; hif.power_on = 1'b1;
        tick();
        count_phase(P_PRE, 4000, n, hl, fl);
        hif.mode = 4'd7;
        count_highs(100, h, fl);
        vectors++; if (h !== 30) begin miscompares++; $display("FAIL mode0_as_mode1: got %0d expected 30", h); end
        count_highs(100, h, fl);
        vectors++; if (h !== 90) begin miscompares++; $display("FAIL mode7_as_mode3: got %0d expected 90", h); end
    endtask

    task automatic test_simultaneous();
        hif.power_on = 1'b0;
        tick();
        hif.power_on = 1'b1;
        tick();
        repeat (2999) tick();
        vectors++; if (hif.phase !== P_PRE) begin miscompares++; $display("FAIL simul_last_preheat: got %0d expected %0d", hif.phase, P_PRE); end
        hif.state = S_PAUSE;
        tick();
        vectors++; if (hif.phase !== P_COOL) begin miscompares++; $display("FAIL simul_state_wins: got %0d expected %0d", hif.phase, P_COOL); end
        vectors++; if (hif.heater !== 1'b0)  begin miscompares++; $display("FAIL simul_heater: got %b expected 0", hif.heater); end
    endtask

    task automatic test_reset_mid();
        int n, hl, fl;
        hif.power_on = 1'b0; hif.state = S_WORK;
        tick();
        hif.power_on = 1'b1;
        tick();
        repeat (1000) tick();
        vectors++; if (hif.phase !== P_PRE) begin miscompares++; $display("FAIL midrst_setup: got %0d expected %0d", hif.phase, P_PRE); end
        #2 rst = 1'b0;
        #1;
        vectors++; if ({hif.heater, hif.fan, hif.busy, hif.phase} !== 5'b00000) begin miscompares++; $display("FAIL midrst_async_clear: got %b expected 00000", {hif.heater, hif.fan, hif.busy, hif.phase}); end
        tick();
        rst = 1'b1;
        #1;
        vectors++; if (hif.phase !== P_OFF) begin miscompares++; $display("FAIL midrst_release_off: got %0d expected %0d", hif.phase, P_OFF); end
        tick();
        count_phase(P_PRE, 4000, n, hl, fl);
        vectors++; if (n !== 3000) begin miscompares++; $display("FAIL midrst_full_preheat: got %0d expected 3000", n); end
        vectors++; if (hif.phase !== P_HEAT) begin miscompares++; $display("FAIL midrst_to_heat: got %0d expected %0d", hif.phase, P_HEAT); end
    endtask

    initial begin
        test_reset();
        test_preheat();
        test_pwm_mode2();
        test_mode_change();
        test_cool();
        test_cool_resume();
        test_power_off();
        test_mode_clamp();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/heat_sequencer.md
Name: heat_sequencer

Overview:
- Drives the heating element and convection fan from the state and mode outputs of the cooking-state controller.
- Sequences each cook through four phases: full-power preheat, mode-dependent PWM heating, fan-only cool-down, then off.
- Sits between the state controller and the heater/fan driver pins.
- Owns all power timing, so the state controller only decides what the cooker is doing, never how the element is switched.

Parameters:
- T_1S, 1000: clk_1Khz ticks per second.
- PWM_PERIOD, 100: heater PWM period in ticks (100 ms).
- DUTY_M1, 30: heater-on ticks per period, mode 1. Must be ≤ PWM_PERIOD.
- DUTY_M2, 60: heater-on ticks per period, mode 2. Must be ≤ PWM_PERIOD.
- DUTY_M3, 90: heater-on ticks per period, mode 3. Must be ≤ PWM_PERIOD.
- PREHEAT_S, 3: preheat duration in seconds.
- COOLDOWN_S, 5: fan run-on after heating stops, in seconds.

Ports:
- clk_1Khz  in  1  system clock, 1 kHz.
- rst  in  1  asynchronous, active-low reset.
- power_on  in  1  master power (SW3); 0 forces everything off.
- state  in  3  cooker state: 0 IDLE, 1 WORK, 2 FINISH, 3 PREPARE, 4 PAUSE.
- mode  in  4  heating mode 1..3. Value 0 is treated as 1; values >3 are treated as 3.
- heater  out  1  heating element drive, active-high.
- fan  out  1  fan drive, active-high.
- phase  out  2  0 OFF, 1 PREHEAT, 2 HEAT, 3 COOL.
- busy  out  1  high whenever phase ≠ OFF.

Behaviour:
- Reset values: heater=0, fan=0, phase=OFF, busy=0. All counters are cleared.
- All outputs are registered. Response is one edge after the input is sampled.
- Counters:
  - ms_cnt counts 0..T_1S-1 and wraps.
  - sec_cnt increments on each ms_cnt wrap.
  - pwm_cnt counts 0..PWM_PERIOD-1 and wraps.
  - Every phase change clears all three counters.
- Priority, highest first: rst, then power_on=0, then the phase transitions below.
- power_on=0 at any phase: next edge gives phase=OFF, heater=0, fan=0. There is no cool-down.
- OFF (heater=0, fan=0):
  - state==WORK with power_on=1 → PREHEAT.
- PREHEAT (heater=1, fan=1):
  - state≠WORK → COOL.
  - Otherwise, the edge at which sec_cnt would reach PREHEAT_S → HEAT. This gives exactly PREHEAT_S*T_1S cycles of preheat.
- HEAT (fan=1):
  - heater = (pwm_cnt < duty_lat).
  - duty_lat is the DUTY_Mx value for the clamped mode.
  - duty_lat is loaded on HEAT entry and at each pwm_cnt wrap. A mode change mid-period takes effect only at the next period boundary, so no runt pulses occur.
  - Duty 0 gives heater constantly 0. Duty equal to PWM_PERIOD gives heater constantly 1.
  - state≠WORK (PAUSE, IDLE, FINISH, PREPARE) → COOL.
- COOL (heater=0, fan=1):
  - state==WORK → HEAT directly, skipping preheat. duty_lat is reloaded.
  - Otherwise, after COOLDOWN_S*T_1S cycles → OFF.
- Simultaneous events:
  - A state change and a timer expiry on the same edge: the state input wins. In PREHEAT with state≠WORK the block goes to COOL, not HEAT.
  - power_on=0 overrides both.
- Reset asserted mid-phase: outputs are zeroed asynchronously. After release the block starts in OFF, even if state==WORK. It then re-enters PREHEAT on the first sampled edge.
- heater is never 1 while fan is 0, in any phase.

Test Plan:
- Reset, power_on=1, state=WORK, mode=2 → phase=PREHEAT and heater=fan=1 one edge later. heater holds 1 for exactly 3000 cycles, then phase=HEAT.
- HEAT, mode=2, observe 300 cycles → heater is 60 high / 40 low in every 100-cycle period. fan stays 1 throughout.
- HEAT, mode=1, switch mode to 3 at pwm_cnt=50 → current period stays at 30 high. The next period is 90 high.
- HEAT, state→PAUSE → heater=0, phase=COOL next edge. fan=1 for exactly 5000 cycles, then phase=OFF, fan=0, busy=0. Repeat with state→WORK after 2000 cycles → phase=HEAT, with no preheat.
- HEAT, power_on→0 → heater=0, fan=0, phase=OFF next edge. Check also mode=0 (behaves as mode 1, 30 high) and mode=7 (behaves as mode 3, 90 high).
- Pulse rst low mid-PREHEAT with state held at WORK → outputs are 0 immediately. After release, the full 3000-cycle preheat restarts.
